// File: rtl/fp_compare_sequencer_pkg.sv
// Shared definitions for the recoded-float compare sequencer:
// opcodes, exception flag positions and the canonical quiet NaN.
package fp_compare_sequencer_pkg;

  typedef enum logic [2:0] {
    FCMP_EQ    = 3'd0,
    FCMP_LT    = 3'd1,
    FCMP_LE    = 3'd2,
    FCMP_MIN   = 3'd3,
    FCMP_MAX   = 3'd4,
    FCMP_UNORD = 3'd5
  } fcmp_op_e;

  localparam int FLAGS_W = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Recoded qNaN: sign 0, exponent top bits 111, fraction MSB set.
  function automatic logic [127:0] canon_nan(
    input int exp_size,
    input int sig_size
  );
    logic [127:0] r;
    r = '0;
    r[exp_size+sig_size-1] = 1'b1;
    r[exp_size+sig_size-2] = 1'b1;
    r[exp_size+sig_size-3] = 1'b1;
    r[sig_size-2] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/compareRecodedFloatN.sv
// Combinational compare of two recoded floats: less, equal, unordered.
// Zeros compare equal regardless of sign; any NaN is unordered.
module compareRecodedFloatN #(
  parameter int expSize = 8,
  parameter int sigSize = 24,
  localparam int W = expSize + sigSize + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         less,
  output logic         equal,
  output logic         unordered
);

  logic         a_sign, b_sign;
  logic         a_nan, b_nan;
  logic         a_zero, b_zero;
  logic [W-2:0] a_mag, b_mag;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_nan  = &a[W-2 -: 3];
  assign b_nan  = &b[W-2 -: 3];
  assign a_zero = (a[W-2 -: 3] == 3'b000);
  assign b_zero = (b[W-2 -: 3] == 3'b000);

  // Recoded exponent ordering is monotonic, so {exp, fract} is a magnitude.
  assign a_mag = a_zero ? '0 : a[W-2:0];
  assign b_mag = b_zero ? '0 : b[W-2:0];

  assign unordered = a_nan | b_nan;

  always_comb begin
    equal = 1'b0;
    less  = 1'b0;
    if (!unordered) begin
      if (a_zero && b_zero) begin
        equal = 1'b1;
      end else begin
        equal = (a_sign == b_sign) && (a_mag == b_mag);
        unique case ({a_sign, b_sign})
          2'b10:   less = 1'b1;
          2'b01:   less = 1'b0;
          2'b00:   less = a_mag < b_mag;
          default: less = a_mag > b_mag;
        endcase
      end
    end
  end

endmodule

// File: rtl/fp_compare_sequencer_arbiter.sv
// Round-robin arbiter: grants the first valid request at or after the
// pointer, and only when enabled; the pointer moves past each grant.
module fp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
      if (gnt_idx == IW'(NUM_REQ - 1)) ptr_d = '0;
      else ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_compare_sequencer.sv
// Shared recoded-float compare unit with round-robin requesters and a
// two-stage pipeline. FP_COMPARE_STICKY_FLAGS_EN adds sticky flags.
module fp_compare_sequencer
  import fp_compare_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int expSize = 8,
  parameter int sigSize = 24,
  localparam int W  = expSize + sigSize + 1,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [W*NUM_REQ-1:0] req_a,
  input  logic [W*NUM_REQ-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IW-1:0]        resp_id,
  output logic [W-1:0]         resp_result,
  output logic [FLAGS_W-1:0]   resp_flags,
  output logic [FLAGS_W-1:0]   sticky_flags,
  input  logic                 flags_clear
);

  localparam logic [127:0] CANON_FULL = canon_nan(expSize, sigSize);
  localparam logic [W-1:0] CANON = CANON_FULL[W-1:0];

  logic               s1_valid_q, s1_valid_d;
  logic [IW-1:0]      s1_id_q, s1_id_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic [W-1:0]       s1_a_q, s1_a_d;
  logic [W-1:0]       s1_b_q, s1_b_d;
  logic               s2_valid_q, s2_valid_d;
  logic [IW-1:0]      s2_id_q, s2_id_d;
  logic [W-1:0]       s2_res_q, s2_res_d;
  logic [FLAGS_W-1:0] s2_flags_q, s2_flags_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               s1_adv, s1_en, s2_load;
  logic               lt, eq, unord;
  logic               a_nan, b_nan, a_snan, b_snan;
  logic               both_zero, nv;
  logic [W-1:0]       res;

  assign s2_load = !s2_valid_q || resp_ready;
  assign s1_adv  = s1_valid_q && s2_load;
  assign s1_en   = !reset && (!s1_valid_q || s1_adv);

  fp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (s1_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;

  compareRecodedFloatN #(.expSize(expSize), .sigSize(sigSize)) u_cmp (
    .a         (s1_a_q),
    .b         (s1_b_q),
    .less      (lt),
    .equal     (eq),
    .unordered (unord)
  );

  assign a_nan     = &s1_a_q[W-2 -: 3];
  assign b_nan     = &s1_b_q[W-2 -: 3];
  assign a_snan    = a_nan && !s1_a_q[sigSize-2];
  assign b_snan    = b_nan && !s1_b_q[sigSize-2];
  assign both_zero = (s1_a_q[W-2 -: 3] == 3'b000)
                  && (s1_b_q[W-2 -: 3] == 3'b000);

  always_comb begin
    res = '0;
    nv  = a_snan || b_snan;
    unique case (s1_op_q)
      FCMP_EQ:    res[0] = eq;
      FCMP_LT: begin
        res[0] = lt;
        nv = nv || unord;
      end
      FCMP_LE: begin
        res[0] = lt || eq;
        nv = nv || unord;
      end
      FCMP_MIN: begin
        if (a_nan && b_nan) res = CANON;
        else if (a_nan) res = s1_b_q;
        else if (b_nan) res = s1_a_q;
        else if (both_zero) res = s1_a_q[W-1] ? s1_a_q : s1_b_q;
        else res = lt ? s1_a_q : s1_b_q;
      end
      FCMP_MAX: begin
        if (a_nan && b_nan) res = CANON;
        else if (a_nan) res = s1_b_q;
        else if (b_nan) res = s1_a_q;
        else if (both_zero) res = s1_a_q[W-1] ? s1_b_q : s1_a_q;
        else res = (!lt && !eq) ? s1_a_q : s1_b_q;
      end
      FCMP_UNORD: res[0] = unord;
      default:    nv = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_en) begin
      s1_valid_d = |gnt;
      s1_id_d    = gnt_idx;
      s1_op_d    = req_op[gnt_idx*3 +: 3];
      s1_a_d     = req_a[gnt_idx*W +: W];
      s1_b_d     = req_b[gnt_idx*W +: W];
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    if (s2_load) begin
      s2_valid_d          = s1_valid_q;
      s2_id_d             = s1_id_q;
      s2_res_d            = res;
      s2_flags_d          = '0;
      s2_flags_d[FLAG_NV] = nv;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign resp_valid  = s2_valid_q;
  assign resp_id     = s2_id_q;
  assign resp_result = s2_res_q;
  assign resp_flags  = s2_flags_q;

`ifdef FP_COMPARE_STICKY_FLAGS_EN
  logic [FLAGS_W-1:0] sticky_q, sticky_d;

  // A clear in the same cycle as a response drops that response's flags.
  always_comb begin
    sticky_d = sticky_q;
    if (flags_clear) sticky_d = '0;
    else if (s2_valid_q && resp_ready) sticky_d = sticky_q | s2_flags_q;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flags_clear;
  assign unused_flags_clear = flags_clear;
  assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fp_compare_sequencer.sv
// Scoreboard bench for fp_compare_sequencer: directed corner cases plus
// randomized traffic checked against a real-valued reference model.
module tb_fp_compare_sequencer;

  localparam int N = 4;
  localparam int W = 33;

  localparam logic [32:0] ONE   = 33'h0_80000000;
  localparam logic [32:0] TWO   = 33'h0_80800000;
  localparam logic [32:0] THREE = 33'h0_80C00000;
  localparam logic [32:0] PZ    = 33'h0_00000000;
  localparam logic [32:0] NZ    = 33'h1_00000000;
  localparam logic [32:0] QNAN  = 33'h0_E0400000;
  localparam logic [32:0] SNAN  = 33'h0_E0000001;
  localparam logic [32:0] CNAN  = 33'h0_E0400000;

  typedef struct packed {
    logic [1:0]  id;
    logic [32:0] res;
    logic [4:0]  fl;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_result;
  logic [4:0]     resp_flags;
  logic [4:0]     sticky_flags;
  logic           flags_clear;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t pend[N];

  fp_compare_sequencer #(.NUM_REQ(N), .expSize(8), .sigSize(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_flags   (resp_flags),
    .sticky_flags (sticky_flags),
    .flags_clear  (flags_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(logic [32:0] x);
    return x[31:29] == 3'b111;
  endfunction

  function automatic real to_real(logic [32:0] x);
    real m;
    real s;
    int  e;
    if (x[31:29] == 3'b000) return 0.0;
    if (x[31:29] == 3'b110) return x[32] ? -1.0e300 : 1.0e300;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[31:23]) - 256;
    s = 1.0;
    if (e > 0) repeat (e) s = s * 2.0;
    else repeat (-e) s = s / 2.0;
    return x[32] ? -m * s : m * s;
  endfunction

  function automatic exp_t model(int id, logic [2:0] op,
                                 logic [32:0] a, logic [32:0] b);
    exp_t e;
    bit   an, bn, unord, lt, eq, nv;
    real  ra, rb;
    an = is_nan(a);
    bn = is_nan(b);
    ra = to_real(a);
    rb = to_real(b);
    unord = an || bn;
    lt = !unord && (ra < rb);
    eq = !unord && (ra == rb);
    nv = (an && !a[22]) || (bn && !b[22]);
    e.id  = 2'(id);
    e.res = '0;
    case (op)
      3'd0: e.res[0] = eq;
      3'd1: begin e.res[0] = lt; nv = nv || unord; end
      3'd2: begin e.res[0] = lt || eq; nv = nv || unord; end
      3'd3, 3'd4: begin
        if (an && bn) e.res = CNAN;
        else if (an) e.res = b;
        else if (bn) e.res = a;
        else if (ra == 0.0 && rb == 0.0)
          e.res = ((op == 3'd3) == a[32]) ? a : b;
        else if (op == 3'd3) e.res = (ra < rb) ? a : b;
        else e.res = (ra > rb) ? a : b;
      end
      3'd5: e.res[0] = unord;
      default: nv = 1'b1;
    endcase
    e.fl = {nv, 4'b0000};
    return e;
  endfunction

  function automatic logic [32:0] rand_val();
    logic       s;
    logic [8:0] ex;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0: return {s, 32'h0};
      1: return {s, 9'b110000000, 23'h0};
      2: return {s, 9'b111000000, 1'b1, 22'($urandom)};
      3: return {s, 9'b111000000, 1'b0, 22'($urandom | 1)};
      default: begin
        ex = 9'(256 + $urandom_range(0, 6) - 3);
        return {s, ex, 2'($urandom_range(0, 3)), 21'h0};
      end
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_req(int i, logic [2:0] op,
                          logic [32:0] a, logic [32:0] b);
    req_op[i*3 +: 3] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic new_req(int i);
    logic [2:0]  op;
    logic [32:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = rand_val();
    b  = ($urandom_range(0, 4) == 0) ? a : rand_val();
    pend[i] = model(i, op, a, b);
    load_req(i, op, a, b);
  endtask

  // Called at a negedge; returns the granted index (-1 if none).
  task automatic cycle(output int g);
    logic [N-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    g = -1;
    if ($countones(req_ready) > 1)
      chk("ready_onehot", 64'(req_ready), 64'(acc));
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        g = i;
        sbq.push_back(pend[i]);
      end
    @(negedge clk);
  endtask

  task automatic issue1(int i, logic [2:0] op, logic [32:0] a,
                        logic [32:0] b, logic [32:0] res, logic [4:0] fl);
    int g;
    bit ok;
    ok = 1'b0;
    pend[i] = '{id: 2'(i), res: res, fl: fl};
    load_req(i, op, a, b);
    for (int k = 0; k < 50 && !ok; k++) begin
      cycle(g);
      if (g == i) ok = 1'b1;
    end
    req_valid[i] = 1'b0;
    if (!ok) chk("issue_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    int g;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 200 && sbq.size() != 0; k++) cycle(g);
    if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'(0));
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic        hold_v = 1'b0;
  logic [39:0] held;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("resp_stable", 64'({resp_id, resp_result, resp_flags}),
            64'(held));
      if (resp_valid && resp_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'(resp_id), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          chk("resp_flags", 64'(resp_flags), 64'(e.fl));
        end
      end
      hold_v = resp_valid && !resp_ready;
      held   = {resp_id, resp_result, resp_flags};
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    int nacc;
    reset       = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    req_a       = '0;
    req_b       = '0;
    resp_ready  = 1'b1;
    flags_clear = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_bus", 64'({resp_id, resp_result, resp_flags}), 64'(0));
    chk("rst_sticky", 64'(sticky_flags), 64'(0));
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single LT with latency check
    issue1(0, 3'd1, ONE, TWO, 33'd1, 5'h00);
    #2;
    chk("latency_n1", 64'(resp_valid), 64'(0));
    @(negedge clk);
    #2;
    chk("latency_n2", 64'(resp_valid), 64'(1));
    @(negedge clk);
    drain();

    issue1(1, 3'd0, PZ, NZ, 33'd1, 5'h00);
    issue1(2, 3'd3, PZ, NZ, NZ, 5'h00);
    issue1(3, 3'd4, NZ, PZ, PZ, 5'h00);
    issue1(0, 3'd4, QNAN, THREE, THREE, 5'h00);
    issue1(1, 3'd4, QNAN, SNAN, CNAN, 5'h10);
    issue1(2, 3'd2, QNAN, ONE, 33'd0, 5'h10);
    issue1(3, 3'd0, QNAN, ONE, 33'd0, 5'h00);
    issue1(0, 3'd7, ONE, ONE, 33'd0, 5'h10);
    issue1(1, 3'd5, ONE, SNAN, 33'd1, 5'h10);
    drain();

`ifdef FP_COMPARE_STICKY_FLAGS_EN
    chk("sticky_set", 64'(sticky_flags), 64'(5'h10));
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    #1;
    chk("sticky_clear", 64'(sticky_flags), 64'(0));
    @(negedge clk);
`else
    chk("sticky_off", 64'(sticky_flags), 64'(0));
`endif

    // Backpressure: three pending, only two fit
    resp_ready = 1'b0;
    new_req(0);
    new_req(1);
    new_req(2);
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(g);
      if (g >= 0) begin
        nacc++;
        req_valid[g] = 1'b0;
      end
    end
    #1;
    chk("bp_accepts", 64'(nacc), 64'(2));
    chk("bp_ready_full", 64'(req_ready), 64'(0));
    @(negedge clk);
    resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    drain();

    // Reset with both stages occupied
    resp_ready = 1'b0;
    new_req(1);
    new_req(3);
    for (int k = 0; k < 4; k++) begin
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    reset = 1'b1;
    sbq.delete();
    req_valid = '0;
    @(negedge clk);
    #2;
    chk("rst_flush_valid", 64'(resp_valid), 64'(0));
    @(negedge clk);
    reset      = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);

    // All requesters continuously valid: order restarts at 0
    for (int i = 0; i < N; i++) new_req(i);
    for (int k = 0; k < 8; k++) begin
      cycle(g);
      chk("rr_order", 64'(g), 64'(k % N));
      if (g >= 0) new_req(g);
    end
    drain();

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) new_req(i);
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
